// File: rtl/lcd_panel_rx.sv
// Panel-side HD44780-style bus responder: decodes instructions/data, keeps display state, models busy time.
// Optional read-back (rd_oe/rd_data plus address advance on data reads) is enabled by defining LCD_READ_EN.
module lcd_panel_rx #(
    parameter int CLK_FREQ = 1,
    parameter int CBITS    = 9,
    parameter int DEPTH    = 32,
    parameter int T_PWR    = 400,
    parameter int T_EXEC   = 37,
    parameter int T_CLEAR  = 152
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] lcd_data,
    output logic [7:0] rd_data,
    output logic       rd_oe,
    output logic       busy_flag,
    output logic [6:0] ddram_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_dir,
    output logic       shift_en,
    output logic       dl,
    output logic       n_lines,
    output logic       font,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       viol
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CBITS-1:0] C_PWR   = CBITS'(T_PWR * CLK_FREQ - 1);
    localparam logic [CBITS-1:0] C_EXEC  = CBITS'(T_EXEC * CLK_FREQ - 1);
    localparam logic [CBITS-1:0] C_CLEAR = CBITS'(T_CLEAR * CLK_FREQ - 1);
    localparam logic [CBITS-1:0] C_DEPTH = CBITS'(DEPTH);
    localparam logic [AW-1:0]    A_ONE   = AW'(1);

    typedef enum logic [1:0] {S_PWR, S_IDLE, S_EXEC, S_CLEAR} state_t;

    state_t           r_state, w_state_nxt;
    logic [CBITS-1:0] r_cnt, w_cnt_nxt;
    logic             r_e_d, r_rs, r_rw;
    logic [7:0]       r_dat;
    logic [AW-1:0]    r_addr;
    logic             r_fill;
    logic             r_disp, r_cursor, r_blink, r_inc, r_shift, r_dl, r_n, r_font;
    logic             r_wr_stb, r_viol;
    logic [6:0]       r_wr_addr;
    logic [7:0]       r_wr_data;

    logic          w_commit, w_wr_commit, w_busy, w_accept, w_viol;
    logic          w_go_exec, w_go_clear, w_fill, w_fill_we, w_clear_done;
    logic [AW-1:0] w_addr_step;

    // A transaction commits on the first e=0 cycle following an e=1 cycle.
    assign w_commit     = r_e_d & ~e;
    assign w_wr_commit  = w_commit & ~r_rw;
    assign w_busy       = (r_state != S_IDLE);
    assign w_accept     = w_wr_commit & ~w_busy;
    assign w_viol       = w_wr_commit & w_busy;
    assign w_addr_step  = r_inc ? r_addr + A_ONE : r_addr - A_ONE;
    assign w_fill_we    = (r_state == S_CLEAR) & r_fill & (r_cnt < C_DEPTH);
    assign w_clear_done = (r_state == S_CLEAR) & (r_cnt == C_CLEAR);

    always_comb begin
        w_go_exec  = 1'b0;
        w_go_clear = 1'b0;
        w_fill     = 1'b0;
        if (r_rs) begin
            w_go_exec = 1'b1;
        end else begin
            casez (r_dat)
                8'b1???????, 8'b01??????, 8'b001?????,
                8'b0001????, 8'b00001???, 8'b000001??: w_go_exec = 1'b1;
                8'b0000001?: w_go_clear = 1'b1;
                8'b00000001: begin
                    w_go_clear = 1'b1;
                    w_fill     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        case (r_state)
            S_PWR: if (r_cnt == C_PWR) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept && w_go_exec)  w_state_nxt = S_EXEC;
                if (w_accept && w_go_clear) w_state_nxt = S_CLEAR;
            end
            S_EXEC: if (r_cnt == C_EXEC) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            S_CLEAR: if (w_clear_done) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_PWR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PWR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_d <= 1'b0; r_rs <= 1'b0; r_rw <= 1'b0; r_dat <= '0;
            r_addr <= '0; r_fill <= 1'b0;
            r_disp <= 1'b0; r_cursor <= 1'b0; r_blink <= 1'b0;
            r_inc <= 1'b1; r_shift <= 1'b0;
            r_dl <= 1'b1; r_n <= 1'b0; r_font <= 1'b0;
            r_wr_stb <= 1'b0; r_wr_addr <= '0; r_wr_data <= '0; r_viol <= 1'b0;
        end else begin
            r_e_d    <= e;
            r_viol   <= w_viol;
            r_wr_stb <= 1'b0;
            if (e) begin
                r_rs  <= rs;
                r_rw  <= rw;
                r_dat <= lcd_data;
            end
            if (w_accept) begin
                if (r_rs) begin
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= 7'(r_addr);
                    r_wr_data <= r_dat;
                    r_addr    <= w_addr_step;
                end else begin
                    casez (r_dat)
                        8'b1???????: r_addr <= r_dat[AW-1:0];
                        8'b01??????: ;
                        8'b001?????: begin
                            r_dl   <= r_dat[4];
                            r_n    <= r_dat[3];
                            r_font <= r_dat[2];
                        end
                        8'b0001????: if (!r_dat[3]) r_addr <= r_dat[2] ? r_addr + A_ONE : r_addr - A_ONE;
                        8'b00001???: begin
                            r_disp   <= r_dat[2];
                            r_cursor <= r_dat[1];
                            r_blink  <= r_dat[0];
                        end
                        8'b000001??: begin
                            r_inc   <= r_dat[1];
                            r_shift <= r_dat[0];
                        end
                        8'b0000001?: r_addr <= '0;
                        default: ;
                    endcase
                    if (w_go_clear) r_fill <= w_fill;
                end
            end
`ifdef LCD_READ_EN
            if (w_commit && r_rw && r_rs) r_addr <= w_addr_step;
`endif
            if (w_fill_we) begin
                r_wr_stb  <= 1'b1;
                r_wr_addr <= 7'(r_cnt[AW-1:0]);
                r_wr_data <= 8'h20;
            end
            if (w_clear_done && r_fill) begin
                r_addr <= '0;
                r_inc  <= 1'b1;
                r_fill <= 1'b0;
            end
        end
    end

`ifdef LCD_READ_EN
    logic [7:0] r_mem [DEPTH];
    logic       r_rd_oe;
    logic [7:0] r_rd_data;

    // Gated by rst so a reset during the clear fill leaves memory partly filled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept && r_rs) r_mem[r_addr] <= r_dat;
            else if (w_fill_we)   r_mem[r_cnt[AW-1:0]] <= 8'h20;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_oe   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_oe   <= e & rw;
            r_rd_data <= (e & rw) ? (rs ? r_mem[r_addr] : {w_busy, 7'(r_addr)}) : 8'h00;
        end
    end

    assign rd_oe   = r_rd_oe;
    assign rd_data = r_rd_data;
`else
    assign rd_oe   = 1'b0;
    assign rd_data = 8'h00;
`endif

    assign busy_flag  = w_busy;
    assign ddram_addr = 7'(r_addr);
    assign disp_on    = r_disp;
    assign cursor_on  = r_cursor;
    assign blink_on   = r_blink;
    assign inc_dir    = r_inc;
    assign shift_en   = r_shift;
    assign dl         = r_dl;
    assign n_lines    = r_n;
    assign font       = r_font;
    assign wr_strobe  = r_wr_stb;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign viol       = r_viol;
endmodule

// File: tb/tb_lcd_panel_rx.sv
// Bench for lcd_panel_rx: scenario tasks with a DDRAM-write scoreboard fed at stimulus time.
module tb_lcd_panel_rx;
    logic       clk = 1'b0, rst = 1'b1, e = 1'b0, rs = 1'b0, rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [7:0] rd_data, wr_data;
    logic [6:0] ddram_addr, wr_addr;
    logic       rd_oe, busy_flag, disp_on, cursor_on, blink_on, inc_dir, shift_en;
    logic       dl, n_lines, font, wr_strobe, viol;

    int checks = 0, errors = 0, cyc = 0;
    logic [14:0] sb_q [$];
    logic [7:0]  tb_mem [32];

    lcd_panel_rx dut (
        .clk(clk), .rst(rst), .e(e), .rs(rs), .rw(rw), .lcd_data(lcd_data),
        .rd_data(rd_data), .rd_oe(rd_oe), .busy_flag(busy_flag), .ddram_addr(ddram_addr),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .inc_dir(inc_dir),
        .shift_en(shift_en), .dl(dl), .n_lines(n_lines), .font(font),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .viol(viol)
    );

    initial forever #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr_bus(input logic r, input logic [7:0] d);
        e = 1'b1; rs = r; rw = 1'b0; lcd_data = d;
        tick();
        e = 1'b0;
        tick();
    endtask

    task automatic exp_write(input int a, input logic [7:0] d);
        sb_q.push_back({7'(a), d});
        tb_mem[a] = d;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_flag === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
    endtask

    initial begin : monitor
        logic [14:0] m_exp;
        forever begin
            @(posedge clk);
            #2;
            if (rst === 1'b0 && wr_strobe === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
                end else begin
                    m_exp = sb_q.pop_front();
                    if ({wr_addr, wr_data} !== m_exp) begin
                        errors++;
                        $display("FAIL wr_event: got addr=%0d data=%h, required addr=%0d data=%h",
                                 wr_addr, wr_data, m_exp[14:8], m_exp[7:0]);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({busy_flag, ddram_addr, disp_on, cursor_on, blink_on} !== {1'b1, 7'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_disp: got busy/addr/dcb=%b/%0d/%b%b%b, required 1/0/000",
                     busy_flag, ddram_addr, disp_on, cursor_on, blink_on);
        end
        checks++;
        if ({inc_dir, shift_en, dl, n_lines, font} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_mode: got %b%b%b%b%b, required 10100", inc_dir, shift_en, dl, n_lines, font);
        end
        checks++;
        if ({rd_oe, rd_data, wr_strobe, viol} !== 11'd0) begin
            errors++;
            $display("FAIL reset_strobes: got rd_oe=%b rd_data=%h wr=%b viol=%b, required zeros",
                     rd_oe, rd_data, wr_strobe, viol);
        end
        rst = 1'b0;
    endtask

    task automatic test_pwr;
        int c0, n;
        c0 = cyc;
        for (int i = 0; i < 98; i++) tick();
        wr_bus(1'b0, 8'h38);
        checks++;
        if (viol !== 1'b1) begin
            errors++;
            $display("FAIL pwr_viol: got %b, required 1", viol);
        end
        tick();
        checks++;
        if ({viol, n_lines} !== 2'b00) begin
            errors++;
            $display("FAIL pwr_dropped: got viol=%b n_lines=%b, required 0 0", viol, n_lines);
        end
        wait_idle(n);
        checks++;
        if (cyc - c0 !== 400) begin
            errors++;
            $display("FAIL pwr_len: got %0d busy cycles, required 400", cyc - c0);
        end
    endtask

    task automatic test_init;
        int n;
        logic [7:0] cmds [3];
        cmds[0] = 8'h38; cmds[1] = 8'h0E; cmds[2] = 8'h06;
        foreach (cmds[i]) begin
            wr_bus(1'b0, cmds[i]);
            wait_idle(n);
            checks++;
            if (n !== 37) begin
                errors++;
                $display("FAIL init_busy: cmd %h got %0d cycles, required 37", cmds[i], n);
            end
        end
        checks++;
        if ({dl, n_lines, font, disp_on, cursor_on, blink_on, inc_dir, shift_en} !== 8'b11011010) begin
            errors++;
            $display("FAIL init_state: got %b%b%b%b%b%b%b%b, required 11011010",
                     dl, n_lines, font, disp_on, cursor_on, blink_on, inc_dir, shift_en);
        end
    endtask

    task automatic test_clear;
        int n;
        for (int i = 0; i < 32; i++) exp_write(i, 8'h20);
        wr_bus(1'b0, 8'h01);
        wait_idle(n);
        checks++;
        if (n !== 152) begin
            errors++;
            $display("FAIL clear_busy: got %0d cycles, required 152", n);
        end
        checks++;
        if ({ddram_addr, inc_dir} !== {7'd0, 1'b1}) begin
            errors++;
            $display("FAIL clear_state: got addr=%0d inc=%b, required 0 1", ddram_addr, inc_dir);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL clear_fill: got %0d writes missing, required 0", sb_q.size());
        end
    endtask

    task automatic test_data_wrap;
        int n;
        wr_bus(1'b0, 8'h9F);
        wait_idle(n);
        checks++;
        if (ddram_addr !== 7'd31) begin
            errors++;
            $display("FAIL set_addr: got %0d, required 31", ddram_addr);
        end
        exp_write(31, 8'h41);
        wr_bus(1'b1, 8'h41);
        wait_idle(n);
        checks++;
        if (n !== 37 || ddram_addr !== 7'd0) begin
            errors++;
            $display("FAIL data_wrap_up: got busy=%0d addr=%0d, required 37 0", n, ddram_addr);
        end
        exp_write(0, 8'h42);
        wr_bus(1'b1, 8'h42);
        wait_idle(n);
        checks++;
        if (ddram_addr !== 7'd1) begin
            errors++;
            $display("FAIL data_addr: got %0d, required 1", ddram_addr);
        end
    endtask

    task automatic test_read;
        int n;
`ifdef LCD_READ_EN
        wr_bus(1'b0, 8'h85);
        e = 1'b1; rw = 1'b1; rs = 1'b0;
        tick();
        checks++;
        if ({rd_oe, rd_data} !== {1'b1, 8'h85}) begin
            errors++;
            $display("FAIL read_status: got oe=%b data=%h, required 1 85", rd_oe, rd_data);
        end
        e = 1'b0;
        tick();
        checks++;
        if ({rd_oe, viol} !== 2'b00) begin
            errors++;
            $display("FAIL read_release: got oe=%b viol=%b, required 0 0", rd_oe, viol);
        end
        wait_idle(n);
        wr_bus(1'b0, 8'h80);
        wait_idle(n);
        e = 1'b1; rw = 1'b1; rs = 1'b1;
        tick();
        checks++;
        if ({rd_oe, rd_data} !== {1'b1, tb_mem[0]}) begin
            errors++;
            $display("FAIL read_data: got oe=%b data=%h, required 1 %h", rd_oe, rd_data, tb_mem[0]);
        end
        e = 1'b0;
        tick();
        checks++;
        if ({ddram_addr, busy_flag, viol} !== {7'd1, 2'b00}) begin
            errors++;
            $display("FAIL read_advance: got addr=%0d busy=%b viol=%b, required 1 0 0", ddram_addr, busy_flag, viol);
        end
`else
        wr_bus(1'b0, 8'h80);
        wait_idle(n);
        e = 1'b1; rw = 1'b1; rs = 1'b1;
        tick();
        checks++;
        if ({rd_oe, rd_data} !== 9'd0) begin
            errors++;
            $display("FAIL noread_bus: got oe=%b data=%h, required 0 00", rd_oe, rd_data);
        end
        e = 1'b0;
        tick();
        checks++;
        if ({ddram_addr, busy_flag, viol} !== {7'd0, 2'b00}) begin
            errors++;
            $display("FAIL noread_ignored: got addr=%0d busy=%b viol=%b, required 0 0 0", ddram_addr, busy_flag, viol);
        end
`endif
        rw = 1'b0;
    endtask

    task automatic test_dec_entry;
        int n;
        wr_bus(1'b0, 8'h04);
        wait_idle(n);
        checks++;
        if ({inc_dir, shift_en} !== 2'b00) begin
            errors++;
            $display("FAIL entry_mode: got inc=%b shift=%b, required 0 0", inc_dir, shift_en);
        end
        wr_bus(1'b0, 8'h80);
        wait_idle(n);
        exp_write(0, 8'h55);
        wr_bus(1'b1, 8'h55);
        wait_idle(n);
        checks++;
        if (ddram_addr !== 7'd31) begin
            errors++;
            $display("FAIL dec_wrap: got %0d, required 31", ddram_addr);
        end
        wr_bus(1'b0, 8'h14);
        wait_idle(n);
        checks++;
        if (ddram_addr !== 7'd0) begin
            errors++;
            $display("FAIL shift_right: got %0d, required 0", ddram_addr);
        end
        wr_bus(1'b0, 8'h10);
        wait_idle(n);
        checks++;
        if (ddram_addr !== 7'd31) begin
            errors++;
            $display("FAIL shift_left: got %0d, required 31", ddram_addr);
        end
        wr_bus(1'b0, 8'h1C);
        wait_idle(n);
        checks++;
        if (n !== 37 || ddram_addr !== 7'd31) begin
            errors++;
            $display("FAIL display_shift: got busy=%0d addr=%0d, required 37 31", n, ddram_addr);
        end
    endtask

    task automatic test_noop;
        wr_bus(1'b0, 8'h00);
        tick();
        checks++;
        if ({busy_flag, viol} !== 2'b00) begin
            errors++;
            $display("FAIL noop: got busy=%b viol=%b, required 0 0", busy_flag, viol);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        wr_bus(1'b0, 8'h85);
        wr_bus(1'b0, 8'h8A);
        checks++;
        if (viol !== 1'b1) begin
            errors++;
            $display("FAIL busy_viol: got %b, required 1", viol);
        end
        wait_idle(n);
        checks++;
        if (ddram_addr !== 7'd5) begin
            errors++;
            $display("FAIL busy_dropped: got addr=%0d, required 5", ddram_addr);
        end
    endtask

    task automatic test_return_home;
        int n;
        wr_bus(1'b0, 8'h02);
        wait_idle(n);
        checks++;
        if (n !== 152 || ddram_addr !== 7'd0) begin
            errors++;
            $display("FAIL home: got busy=%0d addr=%0d, required 152 0", n, ddram_addr);
        end
    endtask

    task automatic test_long_e;
        int n;
        e = 1'b1; rs = 1'b0; rw = 1'b0; lcd_data = 8'h81;
        for (int i = 0; i < 5; i++) tick();
        lcd_data = 8'h83;
        tick();
        e = 1'b0;
        tick();
        wait_idle(n);
        checks++;
        if (n !== 37 || ddram_addr !== 7'd3) begin
            errors++;
            $display("FAIL long_e: got busy=%0d addr=%0d, required 37 3", n, ddram_addr);
        end
    endtask

    initial begin
        test_reset();
        test_pwr();
        test_init();
        test_clear();
        test_data_wrap();
        test_read();
        test_dec_entry();
        test_clear();
        test_noop();
        test_back_to_back();
        test_return_home();
        test_long_e();
        tick(); tick();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending writes, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
